ehgu_ring_fifo: RTL and testbench



---
 rtl/ehgu_basic_pkg.sv | 23 ++
 rtl/ehgu_config_pkg.sv | 4 +
 rtl/ehgu_ring_fifo_if.sv | 16 +
 rtl/ehgu_ring_fifo_mem.sv | 22 ++
 rtl/ehgu_ring_fifo.sv | 73 +++++++
 tb/tb_ehgu_ring_fifo.sv | 161 ++++++++++++++++
 6 files changed

// File: rtl/ehgu_basic_pkg.sv
// Shared arithmetic helpers: modulo increment and binary/thermometer conversion.
package ehgu_basic_pkg;
  localparam int THERM_SIZE = 255;

  function automatic int mod_inc(input int val, input int modulus);
    return (val + 1 >= modulus) ? 0 : val + 1;
  endfunction

  // Bits [lvl-1:0] set; values above THERM_SIZE saturate to all ones.
  function automatic logic [THERM_SIZE-1:0] bin2therm(input int lvl);
    logic [THERM_SIZE-1:0] t;
    t = '0;
    for (int i = 0; i < THERM_SIZE; i++) t[i] = (i < lvl);
    return t;
  endfunction

  function automatic int therm2bin(input logic [THERM_SIZE-1:0] t);
    int n;
    n = 0;
    for (int i = 0; i < THERM_SIZE; i++) n += int'(t[i]);
    return n;
  endfunction
endpackage

// File: rtl/ehgu_config_pkg.sv
// Build-wide datapath configuration shared by EHGU blocks.
package ehgu_config_pkg;
  localparam int DP_WIDTH = 8;
endpackage

// File: rtl/ehgu_ring_fifo_if.sv
// Write/read handshake bundle of the EHGU ring FIFO; slave is the FIFO side.
interface ehgu_ring_fifo_if
  import ehgu_config_pkg::*;
();
  logic                wr_valid;
  logic                wr_ready;
  logic [DP_WIDTH-1:0] wr_data;
  logic                rd_valid;
  logic                rd_ready;
  logic [DP_WIDTH-1:0] rd_data;

  modport master (output wr_valid, wr_data, rd_ready,
                  input  wr_ready, rd_valid, rd_data);
  modport slave  (input  wr_valid, wr_data, rd_ready,
                  output wr_ready, rd_valid, rd_data);
endinterface

// File: rtl/ehgu_ring_fifo_mem.sv
// DEPTH x DP_WIDTH register array: one synchronous write port, one asynchronous read port.
module ehgu_ring_fifo_mem
  import ehgu_config_pkg::*;
#(
  parameter int DEPTH = 5,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [DP_WIDTH-1:0] wdata,
  input  logic [AW-1:0]       raddr,
  output logic [DP_WIDTH-1:0] rdata
);
  logic [DP_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];
endmodule

// File: rtl/ehgu_ring_fifo.sv
// FWFT ring FIFO with arbitrary depth; level, almost-full and, with
// EHGU_RING_FIFO_THERM_EN defined, a thermometer-coded level output.
module ehgu_ring_fifo
  import ehgu_config_pkg::*;
  import ehgu_basic_pkg::*;
#(
  parameter int DEPTH        = 5,
  parameter int AFULL_THRESH = DEPTH - 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  ehgu_ring_fifo_if.slave        bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   afull
`ifdef EHGU_RING_FIFO_THERM_EN
  ,
  output logic [THERM_SIZE-1:0]  level_therm
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  typedef logic [PTR_W:0]   level_t;
  typedef logic [PTR_W-1:0] ptr_t;

  ptr_t   r_wr_ptr;
  ptr_t   r_rd_ptr;
  level_t r_level;
  logic   w_wr_fire;
  logic   w_rd_fire;
  logic   w_mem_we;

  // Flags come only from the registered level, never from the request inputs.
  assign bus.wr_ready = (r_level != level_t'(DEPTH));
  assign bus.rd_valid = (r_level != '0);
  assign afull        = (r_level >= level_t'(AFULL_THRESH));
  assign level        = r_level;

  assign w_wr_fire = bus.wr_valid && bus.wr_ready;
  assign w_rd_fire = bus.rd_valid && bus.rd_ready;
  assign w_mem_we  = w_wr_fire && !flush && !rst;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_fire) r_wr_ptr <= ptr_t'(mod_inc(int'(r_wr_ptr), DEPTH));
      if (w_rd_fire) r_rd_ptr <= ptr_t'(mod_inc(int'(r_rd_ptr), DEPTH));
      case ({w_wr_fire, w_rd_fire})
        2'b10:   r_level <= r_level + level_t'(1);
        2'b01:   r_level <= r_level - level_t'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  ehgu_ring_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_mem_we),
    .waddr (r_wr_ptr),
    .wdata (bus.wr_data),
    .raddr (r_rd_ptr),
    .rdata (bus.rd_data)
  );

`ifdef EHGU_RING_FIFO_THERM_EN
  assign level_therm = bin2therm(int'(r_level));
`endif
endmodule

// File: tb/tb_ehgu_ring_fifo.sv
// Self-checking bench for ehgu_ring_fifo: directed scenarios plus random traffic vs a queue model.
`timescale 1ns/1ps
module tb_ehgu_ring_fifo;
  import ehgu_basic_pkg::*;

  localparam int DEPTH  = 5;
  localparam int AFULL  = 4;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [3:0] level;
  logic       afull;
`ifdef EHGU_RING_FIFO_THERM_EN
  logic [THERM_SIZE-1:0] level_therm;
`endif

  int total;
  int bad;
  int txn;
  logic [7:0] model_q [$];

  ehgu_ring_fifo_if bus ();

  ehgu_ring_fifo #(
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AFULL)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus),
    .level (level),
    .afull (afull)
`ifdef EHGU_RING_FIFO_THERM_EN
    ,
    .level_therm (level_therm)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state();
    int n;
    n = model_q.size();
    chk("level", 32'(level), 32'(n));
    chk("wr_ready", 32'(bus.wr_ready), 32'(n != DEPTH));
    chk("rd_valid", 32'(bus.rd_valid), 32'(n != 0));
    chk("afull", 32'(afull), 32'(n >= AFULL));
    if (n != 0) chk("rd_data", 32'(bus.rd_data), 32'(model_q[0]));
`ifdef EHGU_RING_FIFO_THERM_EN
    chk("therm_lo", level_therm[31:0], (32'd1 << n) - 32'd1);
    chk("therm_hi", 32'(|level_therm[THERM_SIZE-1:32]), 32'd0);
`endif
  endtask

  // One clock: drive requests, check read head, clock, update model, check state.
  task automatic step(input logic wv, input logic [7:0] wd, input logic rr,
                      input logic fl, input logic rs);
    logic wacc;
    logic racc;
    logic [7:0] rexp;
    wacc = wv && (model_q.size() != DEPTH);
    racc = rr && (model_q.size() != 0);
    rexp = racc ? model_q[0] : 8'h00;
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.rd_ready = rr;
    flush        = fl;
    rst          = rs;
    #1;
    if (racc) chk("rd_head", 32'(bus.rd_data), 32'(rexp));
    @(posedge clk);
    #1;
    if (rs || fl) begin
      model_q.delete();
    end else begin
      if (racc) void'(model_q.pop_front());
      if (wacc) model_q.push_back(wd);
    end
    $display("txn %0d wr=%0b/%02h rd=%0b/%02h flush=%0b rst=%0b lvl=%0d",
             txn, wacc, wd, racc, rexp, fl, rs, model_q.size());
    txn++;
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    flush        = 1'b0;
    rst          = 1'b0;
    chk_state();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    txn   = 0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;
    bus.rd_ready = 1'b0;
    flush = 1'b0;
    rst   = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // 1: three writes then three reads in order
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // 2: fill to full, sixth write ignored, then drain
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // 3: wrap-around at level 2
    step(1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h50 + i), 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // 4: simultaneous write+read at level 1
    step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);

    // 5: flush at level 3 together with a write
    step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    step(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // 6: reset mid-stream at level 4, then new word reads back first
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hDD, 1'b1, 1'b1, 1'b1);
    step(1'b1, 8'h5C, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Random traffic with occasional flush/reset
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 50),
           1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
